input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
//
// PURPOSE
// - Conditions one raw, asynchronous single-bit input before bit-level logic
//   consumes it, e.g. the inverter stage that sits directly downstream.
// - Three stages in series: N-flop synchronizer, then a debounce counter, then
//   an optional edge detector.
// - Output is clean, glitch-free and synchronous to clk.
//
// PARAMETERS
// - SYNC_STAGES    2     synchronizer depth; legal range >= 2
// - STABLE_CYCLES  4     consecutive synced cycles a new level must hold
//                        before out follows it; legal range >= 1
// - RESET_VALUE    1'b0  reset value of the sync chain and of out
//
// PORTS
// - clk   in   1  single clock; all state on its rising edge
// - rst   in   1  asynchronous, active-high reset
// - in    in   1  raw asynchronous input
// - out   out  1  synchronized, debounced level
// - rise  out  1  one-cycle pulse when out goes 0->1 (see CONFIGURATION)
// - fall  out  1  one-cycle pulse when out goes 1->0 (see CONFIGURATION)
// - busy  out  1  1 while the debounce counter is nonzero (candidate pending)
//
// BEHAVIOUR
// - Interface: one clock, clk. Reset rst is asynchronous and active-high.
// - Reset state:
//   - sync chain = RESET_VALUE; out = RESET_VALUE
//   - cnt = 0; rise = fall = busy = 0
// - Synchronizer: sync[0] <= in; sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1].
// - Debounce counter cnt, width $clog2(STABLE_CYCLES+1). Per clock:
//   - s == out                       -> cnt <= 0
//   - s != out, cnt == STABLE_CYCLES-1 -> out <= s, cnt <= 0, edge pulse
//   - s != out, otherwise            -> cnt <= cnt + 1
// - Latency: a clean level change on in appears on out at the
//   (SYNC_STAGES + STABLE_CYCLES)th rising edge after the change.
//   Default: 6 edges.
// - Glitch rejection: if s returns to out before STABLE_CYCLES consecutive
//   differing cycles, cnt clears and out is unchanged.
//   - No partial credit: counting restarts from 0 on the next difference.
// - STABLE_CYCLES == 1: out follows s with one register of delay; no filtering.
// - Edge pulses are registered and asserted in the same cycle out takes its new
//   value; high for exactly one cycle. rise and fall are never high together.
// - busy = (cnt != 0), driven from a register (no combinational path from in).
// - Reset mid-debounce:
//   - pending count is discarded; no pulse is emitted
//   - after release, a differing in is debounced from scratch with full latency
// - cnt never exceeds STABLE_CYCLES-1 (no wrap-around).
//
// CONFIGURATION
// - Macro INPUT_CONDITIONER_EDGE_EN:
//   - defined: rise/fall edge-detect registers are built as described above
//   - undefined: rise and fall are tied to 1'b0 and no edge registers are
//     synthesized; out and busy behaviour is identical in both builds
//
// TESTING (defaults SYNC_STAGES=2, STABLE_CYCLES=4, RESET_VALUE=0; run both builds)
// - Reset, then in held 0 for 20 cycles -> out=0, busy=0, rise=fall=0 throughout.
// - in 0->1 held -> out=1 at 6th edge; rise=1 exactly that cycle (EDGE_EN);
//   busy=1 for the 3 preceding cycles.
// - in 1-cycle pulse, then 3-cycle pulse (post-sync) -> out stays 0; no rise;
//   busy returns to 0.
// - out=1, in 1->0 held -> out=0 at 6th edge; fall=1 one cycle (EDGE_EN).
//   Without the macro, rise=fall=0 throughout every test.
// - in=1 and rst asserted asynchronously when cnt=2 -> out=0, cnt=0 immediately.
//   After release with in still 1: out=1 at 6th edge post-release; one rise.
// - Random in toggles with hold times 1..10 -> out matches a reference model
//   cycle-for-cycle; rise&fall never both 1.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronizer, debounce filter and optional edge detector for one raw asynchronous input.
// Define INPUT_CONDITIONER_EDGE_EN to build the rise/fall pulse registers; otherwise they are tied low.
`timescale 1ns/1ps

module input_conditioner #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Any cycle where s agrees with out clears the count: no partial credit for glitches.
  always_comb begin
    cnt_next = '0;
    flip     = 1'b0;
    if (s != out) begin
      if (cnt == CNT_LAST) begin
        flip = 1'b1;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // busy is registered from the next count so it has no combinational path from in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      out  <= RESET_VALUE;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
      if (flip) begin
        out <= s;
      end
    end
  end

`ifdef INPUT_CONDITIONER_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip & s;
      fall <= flip & ~s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and random-hold checks of input_conditioner at default parameters, in either edge build.
`timescale 1ns/1ps

module tb_input_conditioner;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
`ifdef INPUT_CONDITIONER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SYNC-1:0] m_sync;
  logic            m_out;
  logic            m_rise;
  logic            m_fall;
  int              m_run;

  always #5 clk = ~clk;

  input_conditioner #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .RESET_VALUE  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = '0;
    m_out  = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
  endtask

  task automatic model_step();
    logic s;
    s      = m_sync[SYNC-1];
    m_sync = {m_sync[SYNC-2:0], din};
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_out) begin
      m_run++;
      if (m_run == STABLE) begin
        m_out  = s;
        m_run  = 0;
        m_rise = EDGE & s;
        m_fall = EDGE & ~s;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic check_model();
    chk("rand_out", dout, m_out);
    chk("rand_busy", busy, logic'(m_run != 0));
    chk("rand_rise", rise, m_rise);
    chk("rand_fall", fall, m_fall);
    chk("rand_not_both", rise & fall, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    din = 1'b0;
    model_reset();
    #2;
    chk("reset_out", dout, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rise", rise, 1'b0);
    chk("reset_fall", fall, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Quiet input: nothing moves
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_out", dout, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_rise", rise, 1'b0);
      chk("idle_fall", fall, 1'b0);
    end

    // 0->1 held: out at edge 6, busy over edges 3..5
    din = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rise_out", dout, logic'(k >= 6));
      chk("rise_busy", busy, logic'(k >= 3 && k <= 5));
      chk("rise_pulse", rise, logic'(EDGE && k == 6));
      chk("rise_nofall", fall, 1'b0);
    end

    // 1->0 held
    din = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("fall_out", dout, logic'(k < 6));
      chk("fall_busy", busy, logic'(k >= 3 && k <= 5));
      chk("fall_pulse", fall, logic'(EDGE && k == 6));
      chk("fall_norise", rise, 1'b0);
    end

    // One-cycle glitch
    din = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) din = 1'b0;
      tick();
      chk("g1_out", dout, 1'b0);
      chk("g1_busy", busy, logic'(k == 3));
      chk("g1_rise", rise, 1'b0);
    end

    // Three-cycle glitch: counts to 3, never reaches 4
    din = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) din = 1'b0;
      tick();
      chk("g3_out", dout, 1'b0);
      chk("g3_busy", busy, logic'(k >= 3 && k <= 5));
      chk("g3_rise", rise, 1'b0);
      chk("g3_fall", fall, 1'b0);
    end

    // Reset while the count is 2
    din = 1'b1;
    repeat (4) tick();
    chk("mid_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out", dout, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rise", rise, 1'b0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("post_rst_out", dout, logic'(k >= 6));
      chk("post_rst_busy", busy, logic'(k >= 3 && k <= 5));
      chk("post_rst_rise", rise, logic'(EDGE && k == 6));
      chk("post_rst_fall", fall, 1'b0);
    end

    // Random hold times against the reference model
    for (int seg = 0; seg < 40; seg++) begin
      int n;
      din = ~din;
      n = $urandom_range(10, 1);
      for (int j = 0; j < n; j++) begin
        tick();
        check_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
